// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment scan driver.
//   SEG_0..SEG_F, SEG_BLANK : active-low glyphs in {g,f,e,d,c,b,a} order
//   MAX_DIGITS              : widest display the helpers are sized for
//   glyph_of()              : nibble + hex_mode -> glyph (10..15 blank in BCD mode)
//   lz_mask()               : bit i set when digit i is a leading zero
package seg7_pkg;

    localparam int MAX_DIGITS = 16;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Letters only exist in hex mode; in BCD mode an out-of-range nibble
    // shows nothing rather than a misleading letter.
    function automatic logic [6:0] glyph_of(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] g;
        g = SEG_BLANK;
        case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
            default: g = SEG_BLANK;
        endcase
        if (!hex_mode && (nibble > 4'h9)) begin
            g = SEG_BLANK;
        end
        return g;
    endfunction

    // Walk from the most significant digit down; a digit is a leading zero
    // while everything above it (and itself) is zero. Digit 0 always shows.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] digits);
        logic [MAX_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (digits[4*i +: 4] == 4'h0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_glyph_rom.sv
// seg7_glyph_rom
// Combinational glyph lookup for the digit currently being scanned.
//   nibble   : value of the selected digit
//   hex_mode : 1 = show A..F, 0 = blank for 10..15
//   blank    : force all segments off (leading-zero blanking)
//   seg      : active-low segments {g,f,e,d,c,b,a}
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanking overrides whatever the nibble would otherwise show.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = glyph_of(nibble, hex_mode);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed common-anode seven-segment driver with double-buffered
// display data and a dead time at the start of every digit slot.
//   clk, rst_n  : clock, synchronous active-low reset
//   digits_in   : nibble i drives digit i (digit 0 is rightmost)
//   dp_in       : decimal point request per digit
//   digit_en_in : per-digit enable
//   hex_mode_in : hex glyphs when 1, BCD when 0
//   blank_lz_in : blank leading zeros when 1
//   load        : one-cycle capture strobe for all *_in inputs
//   pending     : captured data waiting for the next frame boundary
//   frame_done  : one-cycle pulse after each frame wrap
//   seg, dp, an : active-low pin drives
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    hex_mode_in,
    input  logic                    blank_lz_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp_en;
        logic [NUM_DIGITS-1:0]   en;
        logic                    hex;
        logic                    lz;
    } disp_buf_t;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic                    frame_wrap;
    disp_buf_t               in_buf;
    disp_buf_t               shadow;
    disp_buf_t               active;
    logic [4*MAX_DIGITS-1:0] padded;
    logic [MAX_DIGITS-1:0]   lz_bits;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Bundle the raw inputs so both buffers are written as one unit.
    always_comb begin
        in_buf        = '0;
        in_buf.digits = digits_in;
        in_buf.dp_en  = dp_in;
        in_buf.en     = digit_en_in;
        in_buf.hex    = hex_mode_in;
        in_buf.lz     = blank_lz_in;
    end

    assign frame_wrap = (prescaler == PRESC_LAST) && (idx == IDX_LAST);

    // Slot timer and digit index. Disabled digits still get their slot so
    // the refresh rate never depends on the enable pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Double buffer: active only changes at the frame wrap, so a frame is
    // never drawn from two different values. A load landing exactly on the
    // wrap can go straight to active since the new frame starts next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (frame_wrap) begin
            if (load) begin
                active  <= in_buf;
                pending <= 1'b0;
            end else if (pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end else if (load) begin
            shadow  <= in_buf;
            pending <= 1'b1;
        end
    end

    // Pick the current digit and decide whether it is a leading zero.
    // The helper works on a fixed maximum width, so pad with zeros above.
    always_comb begin
        padded                     = '0;
        padded[4*NUM_DIGITS-1:0]   = active.digits;
        lz_bits                    = lz_mask(padded);
        cur_nibble                 = active.digits[{idx, 2'b00} +: 4];
        cur_blank                  = active.lz & lz_bits[idx];
    end

    seg7_glyph_rom u_glyph_rom (
        .nibble   (cur_nibble),
        .hex_mode (active.hex),
        .blank    (cur_blank),
        .seg      (glyph)
    );

    // Next pin values: everything dark during the dead time, then the glyph
    // with the anode and decimal point only for an enabled digit.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (prescaler >= BLANK_END) begin
            seg_next = glyph;
            if (active.en[idx]) begin
                an_next[idx] = 1'b0;
                dp_next      = ~active.dp_en[idx];
            end
        end
    end

    // Register the pins so they are glitch-free; this adds one cycle of
    // latency behind the slot timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver (4 digits, 6-cycle slots, 2 dead cycles).
// The stimulus process pushes the displays it expects for each frame; a
// separate monitor pops one expectation each time an anode turns on.
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int TD  = 6;
    localparam int BC  = 2;
    localparam int FRM = ND * TD;

    logic          clk;
    logic          rst_n;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en_in;
    logic          hex_mode_in;
    logic          blank_lz_in;
    logic          load;
    logic          pending;
    logic          frame_done;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic            hex;
        logic            lz;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t vecs [10];
    exp_t exp_q [$];

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   act_v = -1;
    int   sh_v = -1;
    bit   model_pending = 1'b0;
    logic [3:0] prev_an = 4'hF;
    int   on_len = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en_in (digit_en_in),
        .hex_mode_in (hex_mode_in),
        .blank_lz_in (blank_lz_in),
        .load        (load),
        .pending     (pending),
        .frame_done  (frame_done),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point for every comparison so the counters stay consistent.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic set_vec(input int k, input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                           input logic h, input logic z,
                           input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        vecs[k].digits  = d;
        vecs[k].dp      = p;
        vecs[k].en      = e;
        vecs[k].hex     = h;
        vecs[k].lz      = z;
        vecs[k].exp_seg = {s3, s2, s1, s0};
    endtask

    // Drive one vector with load asserted; the caller drops load next cycle.
    task automatic applyStimulus(input int k);
        digits_in   = vecs[k].digits;
        dp_in       = vecs[k].dp;
        digit_en_in = vecs[k].en;
        hex_mode_in = vecs[k].hex;
        blank_lz_in = vecs[k].lz;
        load        = 1'b1;
    endtask

    // Queue the displays one frame of vector k should produce, digit 0 first.
    task automatic push_frame(input int k);
        exp_t e;
        if (k >= 0) begin
            for (int i = 0; i < ND; i++) begin
                if (vecs[k].en[i]) begin
                    e.an    = 4'hF;
                    e.an[i] = 1'b0;
                    e.seg   = vecs[k].exp_seg[i];
                    e.dp    = ~vecs[k].dp[i];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Entered at the negedge of a frame-boundary cycle; leaves at the next one.
    // Optional mid-frame loads at offsets 8 and 10 exercise the shadow buffer.
    task automatic run_frame(input int boundary_v, input int mid_a, input int mid_b);
        load = 1'b0;
        if (boundary_v >= 0) begin
            applyStimulus(boundary_v);
            act_v         = boundary_v;
            model_pending = 1'b0;
        end else if (model_pending) begin
            act_v         = sh_v;
            model_pending = 1'b0;
        end
        push_frame(act_v);
        for (int c = 1; c <= FRM; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == 1) begin
                checkOutput("frame_done_pulse", {31'd0, frame_done}, 32'd1);
                checkOutput("pending_after_wrap", {31'd0, pending}, 32'd0);
            end
            if (c == 12) checkOutput("frame_done_idle", {31'd0, frame_done}, 32'd0);
            if (c == 8 && mid_a >= 0) begin
                applyStimulus(mid_a);
                sh_v          = mid_a;
                model_pending = 1'b1;
            end
            if (c == 10 && mid_b >= 0) begin
                applyStimulus(mid_b);
                sh_v          = mid_b;
                model_pending = 1'b1;
            end
            if ((c == 9 && mid_a >= 0) || (c == 11 && mid_b >= 0)) begin
                checkOutput("pending_after_load", {31'd0, pending}, 32'd1);
            end
        end
    endtask

    task automatic check_reset_pins();
        checkOutput("reset_an", {28'd0, an}, 32'hF);
        checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
        checkOutput("reset_dp", {31'd0, dp}, 32'd1);
        checkOutput("reset_pending", {31'd0, pending}, 32'd0);
        checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
    endtask

    // Monitor: each anode turn-on is one display event checked against the
    // queue; each turn-off checks the on-time (slot minus dead time).
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (an != 4'hF && prev_an == 4'hF) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_display_an", {28'd0, an}, 32'hF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("display_an", {28'd0, an}, {28'd0, e.an});
                    checkOutput("display_seg", {25'd0, seg}, {25'd0, e.seg});
                    checkOutput("display_dp", {31'd0, dp}, {31'd0, e.dp});
                end
                on_len = 1;
            end else if (an != 4'hF) begin
                on_len++;
            end else if (prev_an != 4'hF) begin
                checkOutput("anode_on_cycles", on_len, TD - BC);
            end
            prev_an = an;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        set_vec(0, 16'h4321, 4'b0000, 4'b1111, 1'b0, 1'b0, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        set_vec(1, 16'h9999, 4'b0000, 4'b1111, 1'b0, 1'b0, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
        set_vec(2, 16'h1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);
        set_vec(3, 16'hFA98, 4'b0000, 4'b1111, 1'b0, 1'b0, 7'b1111111, 7'b1111111, 7'b0010000, 7'b0000000);
        set_vec(4, 16'hFA98, 4'b0000, 4'b1111, 1'b1, 1'b0, 7'b0001110, 7'b0001000, 7'b0010000, 7'b0000000);
        set_vec(5, 16'hEDCB, 4'b0000, 4'b1111, 1'b1, 1'b0, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011);
        set_vec(6, 16'h0050, 4'b1000, 4'b1111, 1'b0, 1'b1, 7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000);
        set_vec(7, 16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
        set_vec(8, 16'h2468, 4'b0101, 4'b0101, 1'b0, 1'b0, 7'b0100100, 7'b0011001, 7'b0000010, 7'b0000000);
        set_vec(9, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);

        rst_n       = 1'b0;
        load        = 1'b0;
        digits_in   = '0;
        dp_in       = '0;
        digit_en_in = '0;
        hex_mode_in = 1'b0;
        blank_lz_in = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_pins();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (FRM - 1) @(negedge clk);
        checkOutput("first_wrap_no_pulse", {31'd0, frame_done}, 32'd0);

        run_frame(0, -1, -1);
        run_frame(-1, 1, 2);
        run_frame(-1, -1, -1);
        run_frame(3, -1, -1);
        run_frame(4, -1, -1);
        run_frame(5, -1, -1);
        run_frame(6, -1, -1);
        run_frame(7, -1, -1);
        run_frame(8, -1, -1);
        run_frame(9, -1, -1);

        // Leave a load pending, then reset in the middle of digit 1's slot.
        repeat (8) @(negedge clk);
        applyStimulus(0);
        @(negedge clk);
        load = 1'b0;
        checkOutput("pending_before_reset", {31'd0, pending}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_pins();
        rst_n         = 1'b1;
        act_v         = -1;
        sh_v          = -1;
        model_pending = 1'b0;
        repeat (FRM - 1) @(negedge clk);
        checkOutput("restart_wrap_no_pulse", {31'd0, frame_done}, 32'd0);
        run_frame(-1, -1, -1);
        run_frame(-1, -1, -1);

        checkOutput("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
